univ_shift_reg: RTL

Parametrised universal shift register generalising the SISO/SIPO/PISO/PIPO family into one block. It supports hold, logical shift in either direction, rotate, arithmetic shift, parallel load and clear, selected by a mode code. A shift counter with a completion pulse lets a serializer or deserializer built on top know when a full word has moved. It sits between parallel datapaths and serial links and replaces the four fixed-function registers in new designs.

---
 rtl/univ_shift_reg_if.sv | 18 +
 rtl/univ_shift_reg.sv | 50 +++++
 2 files changed

// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control, data and status bundle for the universal shift register
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CW = $clog2(WIDTH+1)
);
  logic en;
  logic [2:0] mode;
  logic si_r;
  logic si_l;
  logic [WIDTH-1:0] pi;
  logic [WIDTH-1:0] po;
  logic so_r;
  logic so_l;
  logic [CW-1:0] shift_cnt;
  logic done;
  modport master (output en, mode, si_r, si_l, pi, input po, so_r, so_l, shift_cnt, done);
  modport slave (input en, mode, si_r, si_l, pi, output po, so_r, so_l, shift_cnt, done);
endinterface

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: hold/shift/rotate/arith-shift/load/clear register with saturating shift counter and done pulse
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int CW = $clog2(WIDTH+1)
) (
  input logic clk,
  input logic reset,
  univ_shift_reg_if.slave bus
);
  localparam logic [2:0] HOLD = 3'b000, SHR = 3'b001, SHL = 3'b010, ROR = 3'b011,
                         ROL = 3'b100, LOAD = 3'b101, ASR = 3'b110, CLEAR = 3'b111;
  logic [WIDTH-1:0] q, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic done_q, shift, zero;
  always_comb begin
    nxt = q;
    case (bus.mode)
      SHR: nxt = {bus.si_r, q[WIDTH-1:1]};
      SHL: nxt = {q[WIDTH-2:0], bus.si_l};
      ROR: nxt = {q[0], q[WIDTH-1:1]};
      ROL: nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      LOAD: nxt = bus.pi;
      ASR: nxt = {q[WIDTH-1], q[WIDTH-1:1]};
      CLEAR: nxt = '0;
      default: nxt = q;
    endcase
    zero = bus.mode == LOAD || bus.mode == CLEAR;
    shift = bus.en && !zero && bus.mode != HOLD;
    cnt_nxt = zero ? '0 : (shift && cnt != CW'(WIDTH)) ? cnt + CW'(1) : cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
      cnt <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= shift && cnt == CW'(WIDTH-1);
      if (bus.en) begin
        q <= nxt;
        cnt <= cnt_nxt;
      end
    end
  end
  assign bus.po = q;
  assign bus.so_r = q[0];
  assign bus.so_l = q[WIDTH-1];
  assign bus.shift_cnt = cnt;
  assign bus.done = done_q;
endmodule
